adc_scan_reader: RTL
====================

Name: adc_scan_reader

Overview:
- Parametrised successor to the single-channel serial ADC bit collector.
- Masters a multi-channel SPI-style ADC: generates sclk/cs_n, shifts a channel address out on mosi, and shifts the conversion result in on miso.
- Strips the leading bits and presents each DATA_W-bit sample with its channel number on a valid/ready output toward the acquisition FIFO/packetiser.
- Scans enabled channels round-robin.

Parameters:
DATA_W, 12, sample width delivered on out_data
LEAD_BITS, 4, leading miso bits per frame, discarded
NUM_CH, 8, number of ADC channels
CH_W, 3, channel index width (ceil log2 NUM_CH)
ADDR_POS, 2, frame bit index where the MSB of the mosi address starts
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
CS_GAP, 2, clk cycles cs_n held high between frames (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  scan enable
ch_mask  in  NUM_CH  per-channel enable, bit i = channel i
sclk  out  1  ADC serial clock, idle high
cs_n  out  1  ADC chip select, active low
mosi  out  1  channel address to ADC
miso  in  1  serial data from ADC, MSB first
out_data  out  DATA_W  sample
out_ch  out  CH_W  channel of out_data
out_valid  out  1  sample available
out_ready  in  1  consumer accepts
overrun  out  1  one-cycle pulse: unconsumed sample overwritten
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: sclk=1, cs_n=1, mosi=0, out_data=0, out_ch=0, out_valid=0, overrun=0, busy=0, state=IDLE, frame count=0.
- Reset asserted mid-frame takes effect immediately (cs_n/sclk high). No partial sample is delivered.
- FRAME_BITS = LEAD_BITS+DATA_W (default 16).
- FSM states:
  - IDLE: leave when en=1 and ch_mask!=0. Select the lowest set mask bit as the first channel and go to SETUP.
  - SETUP: cs_n=0, sclk=1 for CLK_DIV cycles. mosi presents frame bit 0.
  - SHIFT: FRAME_BITS bit periods, each one CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1. mosi updates on each sclk fall. miso is sampled in the clk cycle where sclk goes 0->1.
  - HOLD: cs_n=1, sclk=1 for CS_GAP cycles. On exit go to SETUP if en=1 and ch_mask!=0, else IDLE.
- Frame period = CLK_DIV + 2*CLK_DIV*FRAME_BITS + CS_GAP clk cycles (68 at defaults).
- mosi: frame bits ADDR_POS..ADDR_POS+CH_W-1 carry the addressed channel MSB first. All other bits are 0.
- Pipelining: address sent in frame k selects the conversion returned in frame k+1. out_ch = channel addressed in the previous frame.
  - The first frame after leaving IDLE is a priming frame: its result is discarded and out_valid is not asserted.
- Next channel: lowest set ch_mask bit strictly greater than the current channel, else wrap to the lowest set bit. ch_mask is sampled once per frame at SETUP entry.
- Result: out_data = last DATA_W sampled bits; the first LEAD_BITS are ignored. out_data/out_ch load and out_valid rises in the first HOLD cycle.
- Handshake: transfer when out_valid&&out_ready. out_valid then falls next cycle, unless a new result loads that same cycle, in which case it stays high with no overrun.
  - If a new result loads while out_valid=1 and out_ready=0: overwrite, overrun=1 for that cycle.
- en falling or mask becoming 0 mid-frame: the frame completes and its (non-priming) result is delivered, then IDLE. Re-entry starts with a new priming frame.

Optional Feature:
- Macro ADC_SCAN_TIMESTAMP_EN.
- When defined:
  - Adds output out_ts[15:0] and a 16-bit free-running clk counter (reset 0, wraps at 16'hFFFF->0).
  - The counter value is captured when cs_n falls. out_ts loads alongside out_data with the capture from the frame that carried the data.
- When undefined: no port, no counter, and timing is unchanged.

Test Plan:
- en=1, ch_mask=8'h05, ADC model returns {4'b0, 12'hA00+ch} → mosi addresses 0,2,0,2…; first frame gives no out_valid; then samples (ch0,12'hA00), (ch2,12'hA02), (ch0,12'hA00) at 68-cycle spacing.
- ADC model drives miso=1 during the 4 leading bits, data 12'h5C3 → out_data=12'h5C3 exactly.
- out_ready=0 across two deliveries → second delivery pulses overrun once and out_data holds the newer value; then out_ready=1 for one cycle → out_valid falls next cycle.
- en dropped midway through the third frame → that frame completes, one sample is delivered, cs_n stays 1, busy=0 after HOLD; re-enable → priming frame again.
- ch_mask=0 with en=1 → cs_n stays 1, busy=0. Mask changed 8'h01→8'h80 mid-frame → next address is 7.
- rst pulsed mid-SHIFT → cs_n=1, sclk=1, out_valid=0 asynchronously, with no sample delivered.

Source files
------------

// File: rtl/adc_scan_reader.sv
// adc_scan_reader: masters a multi-channel SPI-style ADC, scanning enabled channels round-robin and
// delivering DATA_W-bit samples with their channel number. Define ADC_SCAN_TIMESTAMP_EN to add out_ts.
module adc_scan_reader #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 4,
  parameter int NUM_CH    = 8,
  parameter int CH_W      = 3,
  parameter int ADDR_POS  = 2,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
`ifdef ADC_SCAN_TIMESTAMP_EN
  ,
  output logic [15:0]       out_ts
`endif
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_W;
  localparam int BIT_W      = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int CNT_MAX    = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] ch;
    ch = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) ch = CH_W'(i);
    end
    return ch;
  endfunction

  // Lowest enabled channel above cur, wrapping to the lowest enabled one.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] cur,
                                              input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] ch;
    logic            found;
    ch    = lowest_ch(mask);
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i] && (i > int'(cur))) begin
        ch    = CH_W'(i);
        found = 1'b1;
      end
    end
    return ch;
  endfunction

  function automatic logic frame_mosi(input logic [CH_W-1:0] ch, input logic [BIT_W-1:0] b);
    int              idx;
    logic [CH_W-1:0] sh;
    idx = int'(b) - ADDR_POS;
    sh  = ch << idx;
    if (idx >= 0 && idx < CH_W) return sh[CH_W-1];
    else return 1'b0;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [BIT_W-1:0]  bit_r, bit_nxt_s;
  logic              half_r, half_nxt_s;
  logic [CH_W-1:0]   addr_r, addr_nxt_s;
  logic [CH_W-1:0]   data_ch_r, data_ch_nxt_s;
  logic              prime_r, prime_nxt_s;
  logic              sample_s, load_s;
  logic [DATA_W-1:0] shift_r;
  logic              sclk_nxt_s, cs_n_nxt_s, mosi_nxt_s, busy_nxt_s;

  // State register and frame sequencing counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_r     <= {BIT_W{1'b0}};
      half_r    <= 1'b1;
      addr_r    <= {CH_W{1'b0}};
      data_ch_r <= {CH_W{1'b0}};
      prime_r   <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_r     <= bit_nxt_s;
      half_r    <= half_nxt_s;
      addr_r    <= addr_nxt_s;
      data_ch_r <= data_ch_nxt_s;
      prime_r   <= prime_nxt_s;
    end
  end

  // Next-state logic; half_r=1 is the sclk-high half of a bit period.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_nxt_s     = bit_r;
    half_nxt_s    = half_r;
    addr_nxt_s    = addr_r;
    data_ch_nxt_s = data_ch_r;
    prime_nxt_s   = prime_r;
    sample_s      = 1'b0;
    load_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en && (ch_mask != {NUM_CH{1'b0}})) begin
          state_nxt_s = ST_SETUP;
          cnt_nxt_s   = {CNT_W{1'b0}};
          bit_nxt_s   = {BIT_W{1'b0}};
          half_nxt_s  = 1'b1;
          addr_nxt_s  = lowest_ch(ch_mask);
          prime_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == DIV_LAST) begin
          state_nxt_s = ST_SHIFT;
          cnt_nxt_s   = {CNT_W{1'b0}};
          bit_nxt_s   = {BIT_W{1'b0}};
          half_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_r != DIV_LAST) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if (!half_r) begin
          cnt_nxt_s  = {CNT_W{1'b0}};
          half_nxt_s = 1'b1;
          sample_s   = 1'b1;
        end else if (bit_r == BIT_LAST) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_HOLD;
          load_s      = !prime_r;
        end else begin
          cnt_nxt_s  = {CNT_W{1'b0}};
          bit_nxt_s  = bit_r + BIT_W'(1);
          half_nxt_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_r != GAP_LAST) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if (en && (ch_mask != {NUM_CH{1'b0}})) begin
          cnt_nxt_s     = {CNT_W{1'b0}};
          state_nxt_s   = ST_SETUP;
          bit_nxt_s     = {BIT_W{1'b0}};
          half_nxt_s    = 1'b1;
          data_ch_nxt_s = addr_r;
          addr_nxt_s    = next_ch(addr_r, ch_mask);
          prime_nxt_s   = 1'b0;
        end else begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pin values for the upcoming state, registered so the ADC sees glitch-free signals.
  always_comb begin
    sclk_nxt_s = 1'b1;
    cs_n_nxt_s = 1'b1;
    mosi_nxt_s = 1'b0;
    busy_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_IDLE:  busy_nxt_s = 1'b0;
      ST_SETUP: begin
        cs_n_nxt_s = 1'b0;
        mosi_nxt_s = frame_mosi(addr_nxt_s, bit_nxt_s);
      end
      ST_SHIFT: begin
        cs_n_nxt_s = 1'b0;
        sclk_nxt_s = half_nxt_s;
        mosi_nxt_s = frame_mosi(addr_nxt_s, bit_nxt_s);
      end
      ST_HOLD:  cs_n_nxt_s = 1'b1;
      default:  busy_nxt_s = 1'b0;
    endcase
  end

  // Serial pins, miso capture and the valid/ready result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk      <= 1'b1;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      shift_r   <= {DATA_W{1'b0}};
      out_data  <= {DATA_W{1'b0}};
      out_ch    <= {CH_W{1'b0}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sclk <= sclk_nxt_s;
      cs_n <= cs_n_nxt_s;
      mosi <= mosi_nxt_s;
      busy <= busy_nxt_s;
      if (sample_s) shift_r <= {shift_r[DATA_W-2:0], miso};
      if (load_s) begin
        out_data  <= shift_r;
        out_ch    <= data_ch_r;
        out_valid <= 1'b1;
        overrun   <= out_valid && !out_ready;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

`ifdef ADC_SCAN_TIMESTAMP_EN
  logic [15:0] ts_cnt_r, ts_cap_r;

  // Free-running timestamp, captured at each cs_n fall and published with that frame's sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_r <= 16'd0;
      ts_cap_r <= 16'd0;
      out_ts   <= 16'd0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 16'd1;
      if (state_nxt_s == ST_SETUP && state_r != ST_SETUP) ts_cap_r <= ts_cnt_r;
      if (load_s) out_ts <= ts_cap_r;
    end
  end
`endif

endmodule
